// File: rtl/fft32_sdf_sequencer.sv
// fft32_sdf_sequencer: one phase counter schedules all five SDF
// butterfly stages, their twiddle ROMs and the output tagging.
module fft32_sdf_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       smp_en,
  output logic [1:0] mode0,
  output logic [1:0] mode1,
  output logic [1:0] mode2,
  output logic [1:0] mode3,
  output logic [1:0] mode4,
  output logic [3:0] tw_addr0,
  output logic [3:0] tw_addr1,
  output logic [3:0] tw_addr2,
  output logic [3:0] tw_addr3,
  output logic       out_valid,
  output logic [4:0] out_idx,
  output logic       frame_done,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_LOAD = 2'b01,
    M_BFLY = 2'b10,
    M_TWID = 2'b11
  } mode_e;

  localparam logic [5:0][4:0] OFF = {
    5'd31, 5'd30, 5'd28, 5'd24, 5'd16, 5'd0
  };
  // phase at which each stage's feedback tail has drained
  localparam logic [4:0][4:0] TEND = {
    5'd31, 5'd30, 5'd28, 5'd24, 5'd16
  };

  logic [4:0]      ph, ph_inc, ph_n;
  logic [5:0]      cur, cur_n;
  logic [4:0]      prev, prev_n;
  logic            start, loading, any_n;
  logic [4:0][4:0] cs;
  logic [4:0]      bf, tl, twsel, ldsel;
  logic [4:0][1:0] mode_n, mode_q;
  logic [3:0][3:0] tw_n, tw_q;
  logic [4:0]      nat, idx_n;
  logic            smp_n, err_n, done_n;

  always_comb begin
    loading = cur[0] && (ph != 5'd31);
    start   = in_valid && (ph == 5'd31);
    ph_inc  = ph + 5'd1;
    cur_n   = cur;
    prev_n  = prev;
    if (ph_inc == OFF[0]) begin
      prev_n[0] = cur[0];
      cur_n[0]  = start;
    end
    for (int s = 1; s < 5; s++) begin
      if (ph_inc == OFF[s]) begin
        prev_n[s] = cur[s];
        cur_n[s]  = cur[s-1];
      end
    end
    for (int s = 0; s < 5; s++) begin
      if (ph_inc == TEND[s]) prev_n[s] = 1'b0;
    end
    if (ph_inc == OFF[5]) cur_n[5] = cur[4];
    any_n  = (|cur_n) || (|prev_n);
    ph_n   = any_n ? ph_inc : 5'd31;
    smp_n  = start || (loading && in_valid);
    err_n  = loading ? !in_valid
                     : (in_valid && !start);
    nat    = ph_n + 5'd1;
    done_n = cur_n[5] && (nat == 5'd31);
    for (int i = 0; i < 5; i++) begin
      idx_n[i] = nat[4-i];
    end
  end

  always_comb begin
    cs     = '0;
    bf     = '0;
    tl     = '0;
    twsel  = '0;
    ldsel  = '0;
    mode_n = '0;
    tw_n   = '0;
    for (int s = 0; s < 5; s++) begin
      cs[s] = ph_n - OFF[s];
      bf[s] = cur_n[s] && cs[s][4-s];
      tl[s] = (cur_n[s] &&
               ((cs[s] >> (5 - s)) != 5'd0)) ||
              (prev_n[s] &&
               ((cs[s] >> (4 - s)) == 5'd0));
      twsel[s] = !bf[s] && tl[s];
      ldsel[s] = !bf[s] && !tl[s] && cur_n[s];
      unique case (1'b1)
        bf[s]:    mode_n[s] = M_BFLY;
        twsel[s]: mode_n[s] = M_TWID;
        ldsel[s]: mode_n[s] = M_LOAD;
        default:  mode_n[s] = M_IDLE;
      endcase
    end
    for (int s = 0; s < 4; s++) begin
      tw_n[s] = twsel[s] ? 4'(cs[s] << s) : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph         <= 5'd31;
      cur        <= '0;
      prev       <= '0;
      mode_q     <= '0;
      tw_q       <= '0;
      smp_en     <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= 5'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ph         <= ph_n;
      cur        <= cur_n;
      prev       <= prev_n;
      mode_q     <= mode_n;
      tw_q       <= tw_n;
      smp_en     <= smp_n;
      out_valid  <= cur_n[5];
      out_idx    <= idx_n;
      frame_done <= done_n;
      err        <= err_n;
      busy       <= any_n;
    end
  end

  assign mode0    = mode_q[0];
  assign mode1    = mode_q[1];
  assign mode2    = mode_q[2];
  assign mode3    = mode_q[3];
  assign mode4    = mode_q[4];
  assign tw_addr0 = tw_q[0];
  assign tw_addr1 = tw_q[1];
  assign tw_addr2 = tw_q[2];
  assign tw_addr3 = tw_q[3];

endmodule

// File: tb/tb_fft32_sdf_sequencer.sv
// tb_fft32_sdf_sequencer: frame-level schedule model checked every
// cycle, plus hand-computed literal points for each scenario.
module tb_fft32_sdf_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       smp_en;
  logic [1:0] mode0, mode1, mode2, mode3, mode4;
  logic [3:0] tw_addr0, tw_addr1, tw_addr2, tw_addr3;
  logic       out_valid;
  logic [4:0] out_idx;
  logic       frame_done, err, busy;

  always #5 clk = ~clk;

  fft32_sdf_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .smp_en(smp_en),
    .mode0(mode0), .mode1(mode1), .mode2(mode2),
    .mode3(mode3), .mode4(mode4),
    .tw_addr0(tw_addr0), .tw_addr1(tw_addr1),
    .tw_addr2(tw_addr2), .tw_addr3(tw_addr3),
    .out_valid(out_valid), .out_idx(out_idx),
    .frame_done(frame_done), .err(err), .busy(busy)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int starts[$];

  logic [1:0] e_md[5];
  logic [3:0] e_tw[5];
  logic       e_ov, e_fd, e_bsy, e_smp, e_err;
  logic [4:0] e_idx;

  logic [1:0] lg_m0[2048], lg_m3[2048];
  logic [3:0] lg_t0[2048], lg_t3[2048];
  logic       lg_ov[2048], lg_fd[2048], lg_bsy[2048];
  logic       lg_err[2048], lg_smp[2048];
  logic [4:0] lg_idx[2048];

  function automatic int off_of(int s);
    case (s)
      0: return 0;
      1: return 16;
      2: return 24;
      3: return 28;
      default: return 30;
    endcase
  endfunction

  function automatic logic [4:0] brev(int n);
    logic [4:0] v, r;
    v = n[4:0];
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  nm, act, exp);
  endtask

  // outputs at cycle k from the list of accepted frame starts
  function automatic void compute_exp(int k);
    int d, b, c, ta, n;
    bit fb, ft, fl;
    e_bsy = 0; e_ov = 0; e_fd = 0; e_idx = 0;
    for (int s = 0; s < 5; s++) begin
      d = 16 >> s; fb = 0; ft = 0; fl = 0; ta = 0;
      foreach (starts[f]) begin
        b = starts[f] + 1 + off_of(s);
        c = k - b;
        if (c >= 0 && c < 32) begin
          e_bsy = 1;
          if ((c % (2 * d)) >= d) fb = 1;
          else if (c >= 2 * d) begin
            ft = 1; ta = (c % (2 * d)) * (16 / d);
          end else fl = 1;
        end else if (c >= 32 && c < 32 + d) begin
          e_bsy = 1; ft = 1; ta = (c - 32) * (16 / d);
        end
      end
      e_md[s] = fb ? 2'd2 : ft ? 2'd3 : fl ? 2'd1 : 2'd0;
      e_tw[s] = (!fb && ft) ? ta[3:0] : 4'd0;
    end
    foreach (starts[f]) begin
      n = k - (starts[f] + 32);
      if (n >= 0 && n < 32) begin
        e_ov = 1; e_bsy = 1; e_idx = brev(n);
        if (n == 31) e_fd = 1;
      end
    end
  endfunction

  function automatic void model_edge(int k, bit v);
    bit ld, al;
    ld = 0;
    foreach (starts[f])
      if (k >= starts[f] + 1 && k <= starts[f] + 31) ld = 1;
    compute_exp(k);
    al = !e_bsy ||
         (starts.size() > 0 && ((k - starts[$]) % 32) == 0);
    e_smp = v && (ld || al);
    e_err = (ld && !v) || (v && !ld && !al);
    if (v && !ld && al) starts.push_back(k);
  endfunction

  task automatic compare();
    string t;
    compute_exp(cyc);
    t = $sformatf("@%0d", cyc);
    chk({"mode0", t}, mode0, e_md[0]);
    chk({"mode1", t}, mode1, e_md[1]);
    chk({"mode2", t}, mode2, e_md[2]);
    chk({"mode3", t}, mode3, e_md[3]);
    chk({"mode4", t}, mode4, e_md[4]);
    chk({"tw0", t}, tw_addr0, e_tw[0]);
    chk({"tw1", t}, tw_addr1, e_tw[1]);
    chk({"tw2", t}, tw_addr2, e_tw[2]);
    chk({"tw3", t}, tw_addr3, e_tw[3]);
    chk({"out_valid", t}, out_valid, e_ov);
    if (e_ov) chk({"out_idx", t}, out_idx, e_idx);
    chk({"frame_done", t}, frame_done, e_fd);
    chk({"busy", t}, busy, e_bsy);
    chk({"smp_en", t}, smp_en, e_smp);
    chk({"err", t}, err, e_err);
  endtask

  task automatic step(bit v);
    if (rst_n) model_edge(cyc, v);
    else begin
      e_smp = 0; e_err = 0;
    end
    in_valid = v;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 2048) begin
      lg_m0[cyc] = mode0;   lg_m3[cyc] = mode3;
      lg_t0[cyc] = tw_addr0; lg_t3[cyc] = tw_addr3;
      lg_ov[cyc] = out_valid; lg_fd[cyc] = frame_done;
      lg_bsy[cyc] = busy;   lg_err[cyc] = err;
      lg_smp[cyc] = smp_en; lg_idx[cyc] = out_idx;
    end
    compare();
  endtask

  task automatic run_seq(int nv, int gap, int mis,
                         int total, output int base);
    base = cyc;
    for (int i = 0; i < total; i++)
      step(((i < nv) && (i != gap)) || (i == mis));
  endtask

  function automatic int count_ov(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(lg_ov[i]);
    return n;
  endfunction

  function automatic int count_err(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(lg_err[i]);
    return n;
  endfunction

  function automatic int count_fd(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(lg_fd[i]);
    return n;
  endfunction

  int b;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_mode0", mode0, 0);
    chk("rst_mode4", mode4, 0);
    chk("rst_tw0", tw_addr0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_err", err, 0);
    chk("rst_smp_en", smp_en, 0);
    rst_n = 1'b1;

    // single frame
    run_seq(32, -1, -1, 72, b);
    chk("A_m0_c1", lg_m0[b+1], 1);
    chk("A_m0_c16", lg_m0[b+16], 1);
    chk("A_m0_c17", lg_m0[b+17], 2);
    chk("A_m0_c32", lg_m0[b+32], 2);
    chk("A_m0_c33", lg_m0[b+33], 3);
    chk("A_m0_c48", lg_m0[b+48], 3);
    chk("A_m0_c49", lg_m0[b+49], 0);
    chk("A_tw0_c40", lg_t0[b+40], 7);
    chk("A_ov_c31", lg_ov[b+31], 0);
    chk("A_ov_c32", lg_ov[b+32], 1);
    chk("A_idx_c33", lg_idx[b+33], 16);
    chk("A_idx_c34", lg_idx[b+34], 8);
    chk("A_idx_c35", lg_idx[b+35], 24);
    chk("A_idx_c63", lg_idx[b+63], 31);
    chk("A_fd_c63", lg_fd[b+63], 1);
    chk("A_busy_c63", lg_bsy[b+63], 1);
    chk("A_busy_c64", lg_bsy[b+64], 0);
    chk("A_m3_c29", lg_m3[b+29], 1);
    chk("A_m3_c31", lg_m3[b+31], 2);
    chk("A_m3_c33", lg_m3[b+33], 3);
    chk("A_tw3_c33", lg_t3[b+33], 0);
    chk("A_tw3_c34", lg_t3[b+34], 8);
    chk("A_tw3_c37", lg_t3[b+37], 0);
    chk("A_tw3_c38", lg_t3[b+38], 8);
    chk("A_ov_count", count_ov(b+1, b+72), 32);
    chk("A_err_count", count_err(b+1, b+72), 0);

    // two back-to-back frames
    run_seq(64, -1, -1, 100, b);
    chk("B_m0_c33", lg_m0[b+33], 3);
    chk("B_m0_c48", lg_m0[b+48], 3);
    chk("B_m0_c49", lg_m0[b+49], 2);
    chk("B_ov_run", count_ov(b+32, b+95), 64);
    chk("B_ov_c96", lg_ov[b+96], 0);
    chk("B_fd_c63", lg_fd[b+63], 1);
    chk("B_fd_c95", lg_fd[b+95], 1);
    chk("B_fd_count", count_fd(b+1, b+100), 2);

    // missing sample 10
    run_seq(32, 10, -1, 72, b);
    chk("C_err_c11", lg_err[b+11], 1);
    chk("C_smp_c10", lg_smp[b+10], 1);
    chk("C_smp_c11", lg_smp[b+11], 0);
    chk("C_err_count", count_err(b+1, b+72), 1);
    chk("C_ov_count", count_ov(b+1, b+72), 32);
    chk("C_fd_c63", lg_fd[b+63], 1);

    // misaligned strobe during drain
    run_seq(32, -1, 37, 72, b);
    chk("D_err_c38", lg_err[b+38], 1);
    chk("D_err_count", count_err(b+1, b+72), 1);
    chk("D_ov_count", count_ov(b+1, b+72), 32);
    chk("D_fd_c63", lg_fd[b+63], 1);
    chk("D_busy_c64", lg_bsy[b+64], 0);

    // reset at cycle 40 of a frame
    run_seq(32, -1, -1, 40, b);
    #2 rst_n = 1'b0;
    #1;
    chk("E_busy", busy, 0);
    chk("E_mode0", mode0, 0);
    chk("E_mode2", mode2, 0);
    chk("E_tw1", tw_addr1, 0);
    chk("E_out_valid", out_valid, 0);
    chk("E_out_idx", out_idx, 0);
    starts.delete();
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    run_seq(32, -1, -1, 72, b);
    chk("E_ov_c31", lg_ov[b+31], 0);
    chk("E_ov_c32", lg_ov[b+32], 1);
    chk("E_fd_c63", lg_fd[b+63], 1);
    chk("E_ov_count", count_ov(b+1, b+72), 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
